// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned
// instructions with their PCs and flushes on an execute-stage redirect.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        InstrValidF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];
  localparam logic [CW:0]   CREDIT_MAX = DEPTH[CW:0];
  localparam logic [31:0]   NOP        = 32'h0000_0013;

  logic [31:0]   reqPc, respPc, targetPc;
  logic [CW-1:0] inflight, discard, count;
  logic [AW-1:0] rdPtr, wrPtr;
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   instrMem [DEPTH];
  logic [CW:0]   credits;
  logic          grant, push, pop, dropResp;

  assign InstrValidF = (count != '0);
  assign InstrF      = InstrValidF ? instrMem[rdPtr] : NOP;
  assign PCF         = InstrValidF ? pcMem[rdPtr] : 32'h0;
  assign PCPlus4F    = InstrValidF ? pcMem[rdPtr] + 32'd4 : 32'h0;

  // Discarded in-flight responses still hold a credit until they return.
  always_comb begin
    credits   = {1'b0, inflight} + {1'b0, count};
    imem_req  = !rst_n && !PCSrcE && (credits < CREDIT_MAX);
    imem_addr = reqPc;
    grant     = imem_req && imem_gnt;
    dropResp  = (discard != '0);
    push      = imem_rvalid && !dropResp && !PCSrcE && !rst_n;
    pop       = InstrValidF && !StallF && !PCSrcE;
    targetPc  = PCTargetE & ~32'h3;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      reqPc    <= RESET_PC;
      respPc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else if (PCSrcE) begin
      reqPc    <= targetPc;
      respPc   <= targetPc;
      inflight <= inflight - CW'(imem_rvalid);
      discard  <= inflight - CW'(imem_rvalid);
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      if (grant) reqPc <= reqPc + 32'd4;
      inflight <= inflight + CW'(grant) - CW'(imem_rvalid);
      if (imem_rvalid && dropResp) discard <= discard - CW'(1);
      if (push) begin
        respPc <= respPc + 32'd4;
        wrPtr  <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= respPc;
      instrMem[wrPtr] <= imem_rdata;
    end
  end

  // The credit rule makes a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst_n) !(push && count == FULL_COUNT));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized scoreboard bench for fetch_prefetch_queue: an in-order memory model
// with tagged responses and an abstract stream model of the fetched PCs.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        StallF = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        InstrValidF;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned tag; int unsigned ready; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t       pend[$];
  exp_t        expQ[$];
  int          nCmp = 0, nBad = 0;
  int          modelCount = 0;
  int unsigned epoch = 0, cyc = 0;
  logic [31:0] modelReqPc = RESET_PC;
  bit          inited = 0;
  int          gntPct = 100, rvPct = 100, latMin = 1, latMax = 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then update the model.
  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] tgt);
    bit    delivered, consume, expReq;
    pend_t p;
    @(negedge clk);
    rst_n     = r;
    StallF    = st;
    PCSrcE    = rd;
    PCTargetE = tgt;
    imem_gnt  = ($urandom_range(99) < gntPct);
    if (!r && pend.size() > 0 && cyc >= pend[0].ready && $urandom_range(99) < rvPct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    expReq = !r && !rd && (pend.size() + modelCount < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, expReq});
    if (inited) begin
      chk("InstrValidF", {31'b0, InstrValidF}, {31'b0, modelCount > 0});
      chk("imem_addr", imem_addr, modelReqPc);
      if (modelCount == 0) begin
        chk("empty_InstrF", InstrF, NOP);
        chk("empty_PCF", PCF, 32'h0);
        chk("empty_PCPlus4F", PCPlus4F, 32'h0);
      end
    end
    if (r) begin
      pend.delete();
      expQ.delete();
      modelCount = 0;
      modelReqPc = RESET_PC;
      epoch++;
      inited = 1;
    end else begin
      consume   = (modelCount > 0) && !st && !rd;
      delivered = 0;
      if (imem_rvalid) begin
        p = pend.pop_front();
        delivered = !rd && (p.tag == epoch);
      end
      if (rd) begin
        modelCount = 0;
        epoch++;
        modelReqPc = tgt & ~32'h3;
        expQ.delete();
      end else begin
        if (imem_req && imem_gnt) begin
          pend.push_back('{addr: modelReqPc, tag: epoch,
                           ready: cyc + $urandom_range(latMax, latMin)});
          expQ.push_back('{pc: modelReqPc, instr: memWord(modelReqPc)});
          modelReqPc = modelReqPc + 32'd4;
        end
        modelCount = modelCount + int'(delivered) - int'(consume);
      end
    end
    cyc++;
  endtask

  // Monitor: whenever the fetch stage takes the head, it must be the next expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n && !PCSrcE && !StallF && InstrValidF === 1'b1) begin
        if (expQ.size() == 0) begin
          chk("unexpected_instr", PCF, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          chk("PCF", PCF, e.pc);
          chk("InstrF", InstrF, e.instr);
          chk("PCPlus4F", PCPlus4F, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    latMin = 3; latMax = 3;
    repeat (8) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0103);
    repeat (15) step(0, 0, 0, 0);

    latMin = 1; latMax = 1;
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0180);
    repeat (8) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0200);
    step(0, 0, 1, 32'h0000_0300);
    repeat (12) step(0, 0, 0, 0);

    latMin = 2; latMax = 2;
    repeat (4) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);

    gntPct = 70; rvPct = 80; latMin = 1; latMax = 4;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(299) == 0, $urandom_range(99) < 30,
           $urandom_range(29) == 0, $urandom);

    gntPct = 100; rvPct = 100;
    repeat (20) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
